muldiv_seq: RTL

- Iterative multi-cycle multiply/divide unit for the RV32M instructions.
- Sits beside the combinational ALU in the execute stage; the core stalls on it through a valid/ready handshake.
- Receives operands plus the instruction funct3, iterates one bit per cycle, and returns the result with a zero flag in the same form as the ALU.

---
 rtl/muldiv_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle with a full-width multiplier.
module muldiv_seq #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   fn,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] out,
  output logic         zero
);

  localparam int unsigned AW = 2 * W;
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [W-1:0]  INT_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    fn_q, fn_d;
  logic [W-1:0]  a_q, a_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          neg_q, neg_d;
  logic [W-1:0]  out_q, out_d;
  logic          zero_q, zero_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;

  // Operand conditioning at the accept edge
  logic         x_signed, y_signed, sx, sy;
  logic         is_div, div_zero, div_ovf;
  logic [W-1:0] x_mag, y_mag;

  assign is_div   = fn[2];
  assign x_signed = !(fn[0] && (fn != 3'd1));
  assign y_signed = x_signed && (fn != 3'd2);
  assign sx       = x_signed && x[W-1];
  assign sy       = y_signed && y[W-1];
  assign x_mag    = sx ? -x : x;
  assign y_mag    = sy ? -y : y;
  assign div_zero = is_div && (y == '0);
  assign div_ovf  = is_div && !fn[0] && (x == INT_MIN) && (y == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [AW-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, x_mag} * {{W{1'b0}}, y_mag};
`endif

  // One iteration: acc holds {hi, lo}; multiply shifts right, divide shifts left
  logic [W:0]    mul_sum, rem_sh, rem_diff;
  logic [AW-1:0] acc_step;

  assign mul_sum  = {1'b0, acc_q[AW-1:W]} + {1'b0, a_q};
  assign rem_sh   = {acc_q[AW-1:W], acc_q[W-1]};
  assign rem_diff = rem_sh - {1'b0, a_q};

  always_comb begin
    acc_step = acc_q;
    if (fn_q[2]) begin
      acc_step = {(rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0]), acc_q[W-2:0], ~rem_diff[W]};
    end else if (acc_q[0]) begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[AW-1:1]};
    end
  end

  // Sign fix-up and result selection, used in the cycle that enters DONE
  logic [AW-1:0] acc_neg;
  logic [W-1:0]  hi_neg, res;

  always_comb begin
    acc_neg = neg_q ? -acc_q : acc_q;
    hi_neg  = neg_q ? -acc_q[AW-1:W] : acc_q[AW-1:W];
    if (fn_q[2] && fn_q[1]) begin
      res = hi_neg;
    end else if (!fn_q[2] && (fn_q[1:0] != 2'd0)) begin
      res = acc_neg[AW-1:W];
    end else begin
      res = acc_neg[W-1:0];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fn_d    = fn_q;
    a_d     = a_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    out_d   = out_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = CALC;
          cnt_d   = CNT_INIT;
          fn_d    = fn;
          a_d     = is_div ? y_mag : x_mag;
          acc_d   = {{W{1'b0}}, (is_div ? x_mag : y_mag)};
          neg_d   = (is_div && fn[1]) ? sx : (sx ^ sy);
          // Special divides preload the final {rem, quot} and skip iteration
          if (div_zero) begin
            acc_d = {x, {W{1'b1}}};
            neg_d = 1'b0;
            cnt_d = '0;
          end else if (div_ovf) begin
            acc_d = {{W{1'b0}}, x};
            neg_d = 1'b0;
            cnt_d = '0;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            acc_d = fast_prod;
            cnt_d = '0;
          end
`endif
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
        end else begin
          out_d   = res;
          zero_d  = (res == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fn_q         <= '0;
      a_q          <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      out_q        <= '0;
      zero_q       <= 1'b1;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fn_q         <= fn_d;
      a_q          <= a_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      out_q        <= out_d;
      zero_q       <= zero_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign out        = out_q;
  assign zero       = zero_q;

endmodule
